// File: rtl/segasys1_sndcmd_queue.sv
// segasys1_sndcmd_queue: queues main-CPU sound commands and hands them one at a time to the sound CPU via latch + NMI
//   CLK48M, RESET_N           : system clock, async active-low reset
//   SNDRQ, SNDNO              : one-cycle push strobe and command byte from the main CPU
//   FLUSH                     : synchronous clear of queue and handshake
//   SCPU_CLK_EN               : sound CPU clock enable, time base for timeout and guard gap
//   SCPU_RD                   : sound CPU latch-read level; its rising edge acknowledges NMI
//   SCPU_CMD, SCPU_NMI        : command latch and NMI request towards the sound CPU
//   COUNT, OVERFLOW, STALE    : occupancy, sticky drop flag, timeout-abandon pulse
module segasys1_sndcmd_queue #(
  parameter int DEPTH_LOG2 = 2,
  parameter int TMO_CYC    = 4096,
  parameter int GAP_CYC    = 64
) (
  input  logic                  CLK48M,
  input  logic                  RESET_N,
  input  logic                  SNDRQ,
  input  logic [7:0]            SNDNO,
  input  logic                  FLUSH,
  input  logic                  SCPU_CLK_EN,
  input  logic                  SCPU_RD,
  output logic [7:0]            SCPU_CMD,
  output logic                  SCPU_NMI,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  STALE
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW = $clog2(TMO_CYC > GAP_CYC ? TMO_CYC : GAP_CYC);
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_END = TW'(TMO_CYC - 1);
  localparam logic [TW-1:0] GAP_END = TW'(GAP_CYC - 1);
  typedef enum logic [1:0] {IDLE, LOAD, NMI, GAP} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] tmr;
  logic rd_q;
  logic pop, push_ok, rd_rise;
  // LOAD is only entered with COUNT!=0, so a pop never underflows
  assign pop = state == LOAD;
  // a pop in the same cycle frees the slot the push needs, even when full
  assign push_ok = SNDRQ & (COUNT != FULL | pop);
  assign rd_rise = SCPU_RD & ~rd_q;
  // when full with a simultaneous push+pop, wr_ptr==rd_ptr: the latch still gets the old head
  always_ff @(posedge CLK48M)
    if (push_ok && !FLUSH) mem[wr_ptr] <= SNDNO;
  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      COUNT    <= '0;
      OVERFLOW <= 1'b0;
      STALE    <= 1'b0;
      SCPU_CMD <= 8'h00;
      SCPU_NMI <= 1'b0;
      tmr      <= '0;
      rd_q     <= 1'b0;
    end else begin
      rd_q  <= SCPU_RD;
      STALE <= 1'b0;
      if (FLUSH) begin
        state    <= IDLE;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        COUNT    <= '0;
        OVERFLOW <= 1'b0;
        SCPU_NMI <= 1'b0;
        tmr      <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        COUNT <= (push_ok & ~pop) ? COUNT + 1'b1 : (pop & ~push_ok) ? COUNT - 1'b1 : COUNT;
        if (SNDRQ & ~push_ok) OVERFLOW <= 1'b1;
        case (state)
          IDLE: if (COUNT != '0) state <= LOAD;
          LOAD: begin
            SCPU_CMD <= mem[rd_ptr];
            SCPU_NMI <= 1'b1;
            tmr      <= '0;
            state    <= NMI;
          end
          // an acknowledge beats a timeout landing in the same cycle
          NMI: if (rd_rise) begin
            SCPU_NMI <= 1'b0;
            tmr      <= '0;
            state    <= GAP;
          end else if (SCPU_CLK_EN) begin
            if (tmr == TMO_END) begin
              STALE    <= 1'b1;
              SCPU_NMI <= 1'b0;
              tmr      <= '0;
              state    <= GAP;
            end else tmr <= tmr + 1'b1;
          end
          // SCPU_CMD is left alone here so a late read still returns the same byte
          GAP: if (SCPU_CLK_EN) begin
            tmr   <= tmr == GAP_END ? '0 : tmr + 1'b1;
            state <= tmr == GAP_END ? IDLE : GAP;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_segasys1_sndcmd_queue.sv
// tb_segasys1_sndcmd_queue: scoreboard bench for the sound-command queue
module tb_segasys1_sndcmd_queue;
  localparam int DL = 2, TMO = 300, GAP = 64;
  logic CLK48M = 0, RESET_N = 1, SNDRQ = 0, FLUSH = 0, SCPU_CLK_EN = 0, SCPU_RD = 0;
  logic [7:0] SNDNO = 0;
  logic [7:0] SCPU_CMD;
  logic SCPU_NMI, OVERFLOW, STALE;
  logic [DL:0] COUNT;
  int checks = 0, errors = 0, en_mode = 2, cyc = 0, en_cnt = 0, stale_seen = 0, stale_exp = 0;
  int acc = 0, loads = 0, rd_cnt = 0, rd_hold = 0, n = 0;
  logic pn = 0;
  logic [7:0] sb[$];

  segasys1_sndcmd_queue #(.DEPTH_LOG2(DL), .TMO_CYC(TMO), .GAP_CYC(GAP)) dut (
    .CLK48M(CLK48M), .RESET_N(RESET_N), .SNDRQ(SNDRQ), .SNDNO(SNDNO), .FLUSH(FLUSH),
    .SCPU_CLK_EN(SCPU_CLK_EN), .SCPU_RD(SCPU_RD), .SCPU_CMD(SCPU_CMD), .SCPU_NMI(SCPU_NMI),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .STALE(STALE));

  always #5 CLK48M = ~CLK48M;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // the only driver of SCPU_CLK_EN, so en_cnt counts exactly the enables seen by each edge
  task automatic step();
    cyc++;
    SCPU_CLK_EN = en_mode == 2 ? 1'b1 : en_mode == 1 ? (cyc % 16 == 0) : ($urandom_range(0, 2) != 0);
    @(posedge CLK48M);
    #1;
    if (SCPU_CLK_EN) en_cnt++;
  endtask

  task automatic push(logic [7:0] b, bit accepted);
    SNDRQ = 1;
    SNDNO = b;
    if (accepted) sb.push_back(b);
    step();
    SNDRQ = 0;
  endtask

  task automatic do_read();
    SCPU_RD = 1;
    step();
    chk("nmi_drop_on_read", SCPU_NMI, 0);
    step();
    step();
    SCPU_RD = 0;
  endtask

  task automatic wait_nmi(output int k);
    k = 0;
    while (!SCPU_NMI && k < 20000) begin
      step();
      k++;
    end
    chk("nmi_wait", SCPU_NMI, 1);
  endtask

  task automatic monitor();
    logic p = 0;
    forever begin
      @(negedge CLK48M);
      if (!RESET_N) p = 0;
      else begin
        if (SCPU_NMI && !p) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL nmi_unexpected cmd %0h exp no command pending", SCPU_CMD);
          end else chk("cmd_order", SCPU_CMD, sb.pop_front());
        end
        p = SCPU_NMI;
        if (STALE) stale_seen++;
      end
    end
  endtask

  task automatic reset_checks(string nm);
    chk({nm, "_nmi"}, SCPU_NMI, 0);
    chk({nm, "_cmd"}, SCPU_CMD, 0);
    chk({nm, "_count"}, COUNT, 0);
    chk({nm, "_ovf"}, OVERFLOW, 0);
    chk({nm, "_stale"}, STALE, 0);
  endtask

  initial begin
    fork monitor(); join_none
    // 1: reset and single-command latency / acknowledge
    #2 RESET_N = 0;
    #2 reset_checks("reset");
    repeat (2) step();
    RESET_N = 1;
    step();
    push(8'h81, 1);
    chk("t1_count_T", COUNT, 1);
    chk("t1_nmi_T", SCPU_NMI, 0);
    step();
    chk("t1_nmi_T1", SCPU_NMI, 0);
    step();
    chk("t1_nmi_T2", SCPU_NMI, 1);
    chk("t1_cmd_T2", SCPU_CMD, 8'h81);
    chk("t1_count_T2", COUNT, 0);
    do_read();
    repeat (3) step();
    chk("t1_gap_nmi_low", SCPU_NMI, 0);
    chk("t1_cmd_held", SCPU_CMD, 8'h81);
    repeat (70) step();
    // 2: five pushes fill latch + FIFO, sixth dropped, in-order delivery with guard gap
    for (int i = 1; i <= 5; i++) push(8'(i), 1);
    chk("t2_count_full", COUNT, 4);
    chk("t2_ovf_clear", OVERFLOW, 0);
    chk("t2_cmd_first", SCPU_CMD, 8'h01);
    push(8'h06, 0);
    chk("t2_count_after_drop", COUNT, 4);
    chk("t2_ovf_set", OVERFLOW, 1);
    for (int i = 0; i < 5; i++) begin
      do_read();
      if (i < 4) begin
        wait_nmi(n);
        chk("t2_gap_len", n, GAP);
      end
    end
    chk("t2_ovf_sticky", OVERFLOW, 1);
    repeat (70) step();
    // 3: push coincident with the pop of a full FIFO is accepted
    FLUSH = 1;
    step();
    FLUSH = 0;
    chk("t3_flush_ovf", OVERFLOW, 0);
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i), 1);
    chk("t3_count_full", COUNT, 4);
    do_read();
    repeat (GAP - 1) step();
    push(8'hB5, 1);
    chk("t3_nmi", SCPU_NMI, 1);
    chk("t3_cmd", SCPU_CMD, 8'hB1);
    chk("t3_count_same", COUNT, 4);
    chk("t3_ovf_clear", OVERFLOW, 0);
    for (int i = 0; i < 5; i++) begin
      do_read();
      if (i < 4) wait_nmi(n);
    end
    repeat (70) step();
    // 4: timeout abandons the command with a STALE pulse, next one follows after the gap
    en_mode = 1;
    push(8'h44, 1);
    push(8'h45, 1);
    wait_nmi(n);
    en_cnt = 0;
    n = 0;
    while (!STALE && n < TMO * 16 + 64) begin
      step();
      n++;
    end
    chk("t4_stale", STALE, 1);
    chk("t4_stale_enables", en_cnt, TMO);
    chk("t4_nmi_dropped", SCPU_NMI, 0);
    stale_exp++;
    en_cnt = 0;
    step();
    chk("t4_stale_pulse", STALE, 0);
    wait_nmi(n);
    chk("t4_gap_enables", en_cnt >= GAP && en_cnt <= GAP + 2, 1);
    chk("t4_next_cmd", SCPU_CMD, 8'h45);
    do_read();
    en_mode = 2;
    repeat (70) step();
    // 5: FLUSH during NMI with three queued, coincident SNDRQ ignored
    for (int i = 1; i <= 6; i++) push(8'hA0 + 8'(i), i < 6);
    chk("t5_ovf", OVERFLOW, 1);
    do_read();
    wait_nmi(n);
    chk("t5_count3", COUNT, 3);
    FLUSH = 1;
    SNDRQ = 1;
    SNDNO = 8'h99;
    step();
    FLUSH = 0;
    SNDRQ = 0;
    sb.delete();
    chk("t5_nmi", SCPU_NMI, 0);
    chk("t5_count", COUNT, 0);
    chk("t5_ovf_cleared", OVERFLOW, 0);
    chk("t5_cmd_kept", SCPU_CMD, 8'hA2);
    repeat (20) step();
    chk("t5_sndrq_ignored_nmi", SCPU_NMI, 0);
    chk("t5_sndrq_ignored_count", COUNT, 0);
    // 6: async reset mid-GAP and mid-NMI, then normal latency
    push(8'hC1, 1);
    push(8'hC2, 1);
    wait_nmi(n);
    do_read();
    repeat (5) step();
    #2 RESET_N = 0;
    #1 reset_checks("t6_gap_reset");
    sb.delete();
    step();
    RESET_N = 1;
    push(8'h33, 1);
    step();
    step();
    chk("t6_nmi33", SCPU_NMI, 1);
    chk("t6_cmd33", SCPU_CMD, 8'h33);
    step();
    #2 RESET_N = 0;
    #1 reset_checks("t6_nmi_reset");
    step();
    RESET_N = 1;
    push(8'h22, 1);
    chk("t6_T", SCPU_NMI, 0);
    step();
    chk("t6_T1", SCPU_NMI, 0);
    step();
    chk("t6_T2_nmi", SCPU_NMI, 1);
    chk("t6_T2_cmd", SCPU_CMD, 8'h22);
    chk("t6_T2_count", COUNT, 0);
    do_read();
    repeat (70) step();
    // 7: random traffic, sound CPU acknowledging after random delays
    en_mode = 0;
    pn = SCPU_NMI;
    for (int i = 0; i < 6000; i++) begin
      SNDRQ = 0;
      if (i < 4000 && acc - loads < 4 && $urandom_range(0, 5) == 0) begin
        SNDRQ = 1;
        SNDNO = 8'($urandom);
        sb.push_back(SNDNO);
        acc++;
      end
      SCPU_RD = rd_hold > 0;
      if (rd_hold > 0) rd_hold--;
      step();
      if (SCPU_NMI && !pn) begin
        loads++;
        chk("rnd_count", COUNT, acc - loads);
        rd_cnt = $urandom_range(1, 20);
      end
      pn = SCPU_NMI;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) rd_hold = $urandom_range(1, 4);
      end
    end
    SNDRQ = 0;
    SCPU_RD = 0;
    step();
    chk("rnd_all_loaded", loads, acc);
    chk("rnd_sb_empty", sb.size(), 0);
    chk("rnd_count_end", COUNT, 0);
    chk("rnd_ovf", OVERFLOW, 0);
    chk("stale_total", stale_seen, stale_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
